// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the encoder and the scan decoder.
// Segment vectors are ordered bit6=a ... bit0=g, active-high.
package seg7_pkg;

    // Glyphs 0-9, A, b, C, d, E, F.
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        SegHex     = 2'd0,
        SegBlank   = 2'd1,
        SegIllegal = 2'd2
    } seg_kind_e;

endpackage

// File: rtl/seg2bin.sv
// Combinational reverse lookup of a 7-segment pattern.
// Ports:
//   seg   - segment pattern (bit6=a ... bit0=g)
//   kind  - SegHex for a legal glyph, SegBlank for all-off, SegIllegal otherwise
//   value - hex value of the glyph, 0 unless kind == SegHex
module seg2bin
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output seg_kind_e  kind,
    output logic [3:0] value
);

    always_comb begin
        kind  = SegIllegal;
        value = 4'h0;
        if (seg == SEG_BLANK) begin
            kind = SegBlank;
        end
        for (int unsigned i = 0; i < 16; i++) begin
            if (seg == SEG_HEX[i]) begin
                kind  = SegHex;
                value = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a time-multiplexed 7-segment bus, captures each digit once its
// pattern has been stable long enough, decodes it back to hex and offers the
// completed frame through a valid/ready handshake.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   seg7, an       - observed segment pattern and one-hot digit enable
//   frame_ready    - consumer accepts the current frame
//   clr_err        - clears err_sticky
//   digits         - decoded frame, digit i in bits [4i+3:4i]
//   digits_valid   - per-digit flag: legal hex glyph captured
//   frame_valid    - frame available, held until accepted
//   err_pattern    - one-cycle pulse on capture of an illegal pattern
//   err_sticky     - latched err_pattern, cleared by clr_err
//   overrun        - one-cycle pulse when a completed frame is dropped
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg7,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic                    frame_ready,
    input  logic                    clr_err,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digits_valid,
    output logic                    frame_valid,
    output logic                    err_pattern,
    output logic                    err_sticky,
    output logic                    overrun
);

    localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   shadow_valid_q, shadow_valid_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   digits_valid_q, digits_valid_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    err_pattern_q, err_detect;
    logic                    err_sticky_q, err_sticky_d;
    logic                    overrun_q, overrun_d;

    logic      onehot, same, capture, complete;
    seg_kind_e kind;
    logic [3:0] value;

    seg2bin u_seg2bin (
        .seg   (seg_q),
        .kind  (kind),
        .value (value)
    );

    // cnt describes the sample held in {an_q, seg_q}: it is updated on the same
    // edge that loads the sample, by comparing the incoming sample with the one
    // being replaced. Hence a held pattern reaches STABLE_CYCLES after exactly
    // STABLE_CYCLES edges, and at capture seg_q/an_q already hold that pattern.
    always_comb begin
        onehot   = (an != '0) && ((an & (an - NUM_DIGITS'(1))) == '0);
        same     = (an == an_q) && (seg7 == seg_q);
        capture  = onehot && same && (cnt_q == CNT_MAX - CNT_W'(1));
        complete = &seen_q;

        if (!onehot) begin
            cnt_d = '0;
        end else if (!same) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_comb begin
        seen_d         = seen_q;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        digits_d       = digits_q;
        digits_valid_d = digits_valid_q;
        frame_valid_d  = frame_valid_q;
        err_detect     = 1'b0;
        overrun_d      = 1'b0;

        if (complete) begin
            seen_d = '0;
        end

        if (capture) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (an_q[i]) begin
                    seen_d[i] = 1'b1;
                    case (kind)
                        SegHex: begin
                            shadow_d[4*i +: 4] = value;
                            shadow_valid_d[i]  = 1'b1;
                        end
                        SegBlank: begin
                            shadow_valid_d[i] = 1'b0;
                        end
                        default: begin
                            shadow_valid_d[i] = 1'b0;
                            err_detect        = 1'b1;
                        end
                    endcase
                end
            end
        end

        if (frame_valid_q && frame_ready) begin
            frame_valid_d = 1'b0;
        end
        if (complete) begin
            if (!frame_valid_q || frame_ready) begin
                digits_d       = shadow_q;
                digits_valid_d = shadow_valid_q;
                frame_valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        // Setting takes priority over a simultaneous clear.
        err_sticky_d = (err_sticky_q & ~clr_err) | err_detect;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q          <= '0;
            an_q           <= '0;
            cnt_q          <= '0;
            seen_q         <= '0;
            shadow_q       <= '0;
            shadow_valid_q <= '0;
            digits_q       <= '0;
            digits_valid_q <= '0;
            frame_valid_q  <= 1'b0;
            err_pattern_q  <= 1'b0;
            err_sticky_q   <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            seg_q          <= seg7;
            an_q           <= an;
            cnt_q          <= cnt_d;
            seen_q         <= seen_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
            digits_q       <= digits_d;
            digits_valid_q <= digits_valid_d;
            frame_valid_q  <= frame_valid_d;
            err_pattern_q  <= err_detect;
            err_sticky_q   <= err_sticky_d;
            overrun_q      <= overrun_d;
        end
    end

    assign digits       = digits_q;
    assign digits_valid = digits_valid_q;
    assign frame_valid  = frame_valid_q;
    assign err_pattern  = err_pattern_q;
    assign err_sticky   = err_sticky_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg7;
    logic [3:0]  an;
    logic        frame_ready;
    logic        clr_err;
    logic [15:0] digits;
    logic [3:0]  digits_valid;
    logic        frame_valid;
    logic        err_pattern;
    logic        err_sticky;
    logic        overrun;

    seg7_scan_decoder #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seg7         (seg7),
        .an           (an),
        .frame_ready  (frame_ready),
        .clr_err      (clr_err),
        .digits       (digits),
        .digits_valid (digits_valid),
        .frame_valid  (frame_valid),
        .err_pattern  (err_pattern),
        .err_sticky   (err_sticky),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_errp   = 0;
    int n_ovr    = 0;

    logic [6:0] hp [16];
    localparam logic [6:0] ILLEGAL = 7'b1111100;
    localparam logic [6:0] BLANK   = 7'b0000000;

    typedef struct {
        logic [6:0]  p0, p1, p2, p3;
        logic [15:0] exp_digits;
        logic [3:0]  exp_valid;
        int          exp_err;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock; outputs are observed 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (err_pattern) n_errp++;
        if (overrun) n_ovr++;
    endtask

    task automatic drive_digit(input int idx, input logic [6:0] pat, input int hold,
                               input int gap);
        an   = 4'(1 << idx);
        seg7 = pat;
        repeat (hold) tick();
        an   = '0;
        seg7 = BLANK;
        repeat (gap) tick();
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                        input logic [6:0] p3);
        drive_digit(0, p0, 6, 2);
        drive_digit(1, p1, 6, 2);
        drive_digit(2, p2, 6, 2);
        drive_digit(3, p3, 6, 2);
    endtask

    task automatic wait_frame(input string name, input int budget);
        int n = 0;
        while (!frame_valid && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(frame_valid), 32'd1);
    endtask

    task automatic accept(input string name);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check(name, 32'(frame_valid), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " digits"}, 32'(digits), 32'd0);
        check({tag, " digits_valid"}, 32'(digits_valid), 32'd0);
        check({tag, " frame_valid"}, 32'(frame_valid), 32'd0);
        check({tag, " err_pattern"}, 32'(err_pattern), 32'd0);
        check({tag, " err_sticky"}, 32'(err_sticky), 32'd0);
        check({tag, " overrun"}, 32'(overrun), 32'd0);
    endtask

    task automatic set_vec(input int k, input logic [6:0] p0, input logic [6:0] p1,
                           input logic [6:0] p2, input logic [6:0] p3,
                           input logic [15:0] d, input logic [3:0] v, input int e);
        vecs[k].p0 = p0;
        vecs[k].p1 = p1;
        vecs[k].p2 = p2;
        vecs[k].p3 = p3;
        vecs[k].exp_digits = d;
        vecs[k].exp_valid  = v;
        vecs[k].exp_err    = e;
    endtask

    initial begin
        int e0;
        hp = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
               7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

        // Blank/illegal digits keep the previous vector's shadow value.
        set_vec(0, hp[1], hp[2], hp[3], hp[4], 16'h4321, 4'hF, 0);
        set_vec(1, hp[10], hp[11], hp[12], hp[13], 16'hDCBA, 4'hF, 0);
        set_vec(2, hp[5], hp[6], ILLEGAL, hp[8], 16'h8C65, 4'b1011, 1);
        set_vec(3, hp[14], BLANK, hp[15], hp[0], 16'h0F6E, 4'b1101, 0);
        set_vec(4, hp[7], hp[9], hp[8], hp[15], 16'hF897, 4'hF, 0);

        rst_n = 1'b0;
        seg7 = BLANK;
        an = '0;
        frame_ready = 1'b0;
        clr_err = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Table-driven frames.
        for (int k = 0; k < 5; k++) begin
            e0 = n_errp;
            scan(vecs[k].p0, vecs[k].p1, vecs[k].p2, vecs[k].p3);
            wait_frame($sformatf("vec%0d frame_valid", k), 5);
            check($sformatf("vec%0d digits", k), 32'(digits), 32'(vecs[k].exp_digits));
            check($sformatf("vec%0d digits_valid", k), 32'(digits_valid),
                  32'(vecs[k].exp_valid));
            check($sformatf("vec%0d err_pulses", k), 32'(n_errp - e0), 32'(vecs[k].exp_err));
            accept($sformatf("vec%0d frame_valid after accept", k));
        end

        // Sticky error survives until clr_err.
        check("err_sticky held", 32'(err_sticky), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("err_sticky cleared", 32'(err_sticky), 32'd0);

        // Short dwell is not captured; last full dwell on digit 0 wins.
        drive_digit(1, hp[1], 6, 2);
        drive_digit(2, hp[2], 6, 2);
        drive_digit(3, hp[3], 6, 2);
        drive_digit(0, hp[0], 3, 8);
        check("short dwell no frame", 32'(frame_valid), 32'd0);
        drive_digit(0, hp[0], 3, 0);
        drive_digit(0, hp[10], 6, 2);
        wait_frame("short dwell frame_valid", 5);
        check("short dwell digits", 32'(digits), 32'h321A);
        check("short dwell digits_valid", 32'(digits_valid), 32'hF);
        accept("short dwell accept");

        // Overrun: second frame dropped, first held.
        n_ovr = 0;
        scan(hp[1], hp[2], hp[3], hp[4]);
        wait_frame("overrun first frame", 5);
        scan(hp[5], hp[6], hp[7], hp[8]);
        check("overrun pulses", 32'(n_ovr), 32'd1);
        check("overrun frame_valid held", 32'(frame_valid), 32'd1);
        check("overrun digits held", 32'(digits), 32'h4321);
        accept("overrun accept");

        // Multi-hot enable is never captured; blanking gaps are harmless.
        an = 4'b0011;
        seg7 = hp[9];
        repeat (10) tick();
        an = '0;
        seg7 = BLANK;
        repeat (2) tick();
        drive_digit(2, hp[2], 6, 3);
        drive_digit(3, hp[3], 6, 3);
        check("multi-hot no frame", 32'(frame_valid), 32'd0);
        drive_digit(0, hp[0], 6, 3);
        drive_digit(1, hp[1], 6, 3);
        wait_frame("multi-hot frame_valid", 5);
        check("multi-hot digits", 32'(digits), 32'h3210);
        accept("multi-hot accept");

        // Reset mid-frame discards partial state.
        drive_digit(0, hp[9], 6, 2);
        drive_digit(1, hp[8], 6, 2);
        drive_digit(2, hp[7], 6, 2);
        rst_n = 1'b0;
        tick();
        check_all_zero("mid reset");
        rst_n = 1'b1;
        tick();
        drive_digit(3, hp[6], 6, 8);
        check("post reset partial no frame", 32'(frame_valid), 32'd0);
        scan(hp[9], hp[8], hp[7], hp[6]);
        wait_frame("post reset frame_valid", 5);
        check("post reset digits", 32'(digits), 32'h6789);
        check("post reset digits_valid", 32'(digits_valid), 32'hF);
        accept("post reset accept");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
